// File: rtl/ar_viewport_pkg.sv
// ar_viewport_pkg: shared widths, divider length and FSM state encodings for ar_viewport
package ar_viewport_pkg;
    localparam int AR_W       = 12;
    localparam int AR_DIV_CYC = 2 * AR_W;
    localparam int MODE_ABS   = 12;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MUL    = 3'd1;
    localparam logic [2:0] S_DIV    = 3'd2;
    localparam logic [2:0] S_FIT    = 3'd3;
    localparam logic [2:0] S_MUL2   = 3'd4;
    localparam logic [2:0] S_DIV2   = 3'd5;
    localparam logic [2:0] S_CENTER = 3'd6;
    localparam logic [2:0] S_COMMIT = 3'd7;
endpackage

// File: rtl/ar_viewport_udiv.sv
// ar_viewport_udiv: sequential restoring divider, 2W-bit numerator by W-bit denominator, one quotient bit per cycle
module ar_viewport_udiv
    import ar_viewport_pkg::*;
#(
    parameter int W       = AR_W,
    parameter int DIV_CYC = AR_DIV_CYC
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] num,
    input  logic [W-1:0]   den,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] quotient
);
    localparam int CW = $clog2(DIV_CYC + 1);
    logic [2*W-1:0] quo_q, quo_d;
    logic [W-1:0]   rem_q, rem_d, den_q, den_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic [W:0]     rem_sh;
    logic           ge;
    always_comb begin
        rem_sh = {rem_q, quo_q[2*W-1]};
        ge     = rem_sh >= {1'b0, den_q};
        quo_d  = quo_q;
        rem_d  = rem_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            quo_d  = num;
            rem_d  = '0;
            den_d  = den;
            cnt_d  = CW'(DIV_CYC);
            busy_d = 1'b1;
        end else if (busy_q) begin
            quo_d  = {quo_q[2*W-2:0], ge};
            rem_d  = ge ? W'(rem_sh - {1'b0, den_q}) : rem_sh[W-1:0];
            cnt_d  = cnt_q - CW'(1);
            busy_d = cnt_q != CW'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end
    assign busy     = busy_q;
    assign done     = busy_q && cnt_q == CW'(1);
    assign quotient = quo_q;
endmodule

// File: rtl/ar_viewport.sv
// ar_viewport: turns VIDEO_ARX/ARY into a centred, atomically committed output window once per changed frame
module ar_viewport
    import ar_viewport_pkg::*;
#(
    parameter int W       = AR_W,
    parameter int DIV_CYC = AR_DIV_CYC
) (
    input  logic         CLK_VIDEO,
    input  logic         RESET_N,
    input  logic         VGA_VS,
    input  logic [W:0]   VIDEO_ARX,
    input  logic [W:0]   VIDEO_ARY,
    input  logic [W-1:0] HDMI_WIDTH,
    input  logic [W-1:0] HDMI_HEIGHT,
    output logic [W-1:0] WIN_HMIN,
    output logic [W-1:0] WIN_HMAX,
    output logic [W-1:0] WIN_VMIN,
    output logic [W-1:0] WIN_VMAX,
    output logic         WIN_VALID,
    output logic         WIN_UPDATE
);
    localparam int CFG_W = 4 * W + 2;
    logic [2:0]       state_q, state_d;
    logic             vs_q;
    logic [CFG_W-1:0] snap_q, snap_d, comm_q, comm_d, cfg_in;
    logic             committed_q, committed_d;
    logic             refit_q, refit_d;
    logic             go_q, go_d;
    logic [W-1:0]     w_q, w_d, h_q, h_d;
    logic [2*W-1:0]   prod_q, prod_d;
    logic [W-1:0]     hmin_q, hmin_d, hmax_q, hmax_d, vmin_q, vmin_d, vmax_q, vmax_d;
    logic             valid_q, valid_d;
    logic [W-1:0]     s_ax, s_ay, s_hw, s_hh, in_ax, in_ay;
    logic             in_zero, in_abs, in_full;
    logic             div_start, div_busy, div_done;
    logic [2*W-1:0]   quo;
    logic [W-1:0]     qsat, h_use, hmin_c, vmin_c;
    assign cfg_in    = {VIDEO_ARX, VIDEO_ARY, HDMI_WIDTH, HDMI_HEIGHT};
    assign s_hh      = snap_q[W-1:0];
    assign s_hw      = snap_q[2*W-1:W];
    assign s_ay      = snap_q[3*W-1:2*W];
    assign s_ax      = snap_q[4*W:3*W+1];
    assign div_start = go_q && !div_busy;
    ar_viewport_udiv #(.W(W), .DIV_CYC(DIV_CYC)) u_div (
        .clk      (CLK_VIDEO),
        .rst_n    (RESET_N),
        .start    (div_start),
        .num      (prod_q),
        .den      (state_q == S_DIV ? s_ay : s_ax),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quo)
    );
    always_comb begin
        in_ax       = VIDEO_ARX[W-1:0];
        in_ay       = VIDEO_ARY[W-1:0];
        in_zero     = HDMI_WIDTH == '0 || HDMI_HEIGHT == '0;
        in_abs      = VIDEO_ARX[MODE_ABS] && VIDEO_ARY[MODE_ABS];
        in_full     = (VIDEO_ARX[MODE_ABS] ^ VIDEO_ARY[MODE_ABS]) || in_ax == '0 || in_ay == '0;
        qsat        = |quo[2*W-1:W] ? '1 : quo[W-1:0];
        h_use       = refit_q ? qsat : h_q;
        hmin_c      = (s_hw - w_q) >> 1;
        vmin_c      = (s_hh - h_use) >> 1;
        go_d        = state_q == S_MUL || state_q == S_MUL2;
        prod_d      = state_q == S_MUL2 ? {{W{1'b0}}, s_hw} * {{W{1'b0}}, s_ay}
                    : state_q == S_MUL  ? {{W{1'b0}}, s_hh} * {{W{1'b0}}, s_ax} : prod_q;
        state_d     = state_q;
        snap_d      = snap_q;
        comm_d      = comm_q;
        committed_d = committed_q;
        refit_d     = refit_q;
        w_d         = w_q;
        h_d         = h_q;
        hmin_d      = hmin_q;
        hmax_d      = hmax_q;
        vmin_d      = vmin_q;
        vmax_d      = vmax_q;
        valid_d     = valid_q;
        case (state_q)
            S_IDLE: begin
                refit_d = 1'b0;
                if (VGA_VS && !vs_q && (!committed_q || cfg_in != comm_q)) begin
                    snap_d  = cfg_in;
                    w_d     = HDMI_WIDTH;
                    h_d     = HDMI_HEIGHT;
                    state_d = S_CENTER;
                    if (!in_zero && in_abs) begin
                        w_d = (in_ax == '0 || in_ax > HDMI_WIDTH) ? HDMI_WIDTH : in_ax;
                        h_d = (in_ay == '0 || in_ay > HDMI_HEIGHT) ? HDMI_HEIGHT : in_ay;
                    end else if (!in_zero && !in_full) begin
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL:  state_d = S_DIV;
            S_DIV:  state_d = div_done ? S_FIT : S_DIV;
            S_FIT: begin
                refit_d = qsat > s_hw;
                w_d     = refit_d ? s_hw : qsat;
                state_d = refit_d ? S_MUL2 : S_CENTER;
            end
            S_MUL2: state_d = S_DIV2;
            S_DIV2: state_d = div_done ? S_CENTER : S_DIV2;
            S_CENTER: begin
                valid_d     = s_hw != '0 && s_hh != '0;
                hmin_d      = valid_d ? hmin_c : '0;
                hmax_d      = valid_d ? hmin_c + w_q - W'(1) : '0;
                vmin_d      = valid_d ? vmin_c : '0;
                vmax_d      = valid_d ? vmin_c + h_use - W'(1) : '0;
                comm_d      = snap_q;
                committed_d = 1'b1;
                state_d     = S_COMMIT;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            vs_q        <= 1'b0;
            snap_q      <= '0;
            comm_q      <= '0;
            committed_q <= 1'b0;
            refit_q     <= 1'b0;
            go_q        <= 1'b0;
            w_q         <= '0;
            h_q         <= '0;
            prod_q      <= '0;
            hmin_q      <= '0;
            hmax_q      <= '0;
            vmin_q      <= '0;
            vmax_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_q        <= VGA_VS;
            snap_q      <= snap_d;
            comm_q      <= comm_d;
            committed_q <= committed_d;
            refit_q     <= refit_d;
            go_q        <= go_d;
            w_q         <= w_d;
            h_q         <= h_d;
            prod_q      <= prod_d;
            hmin_q      <= hmin_d;
            hmax_q      <= hmax_d;
            vmin_q      <= vmin_d;
            vmax_q      <= vmax_d;
            valid_q     <= valid_d;
        end
    end
    assign WIN_HMIN   = hmin_q;
    assign WIN_HMAX   = hmax_q;
    assign WIN_VMIN   = vmin_q;
    assign WIN_VMAX   = vmax_q;
    assign WIN_VALID  = valid_q;
    assign WIN_UPDATE = state_q == S_COMMIT;
endmodule
